mem_responder: RTL and testbench

- Memory-side responder for the LSU/IFU data-memory interface.
- Accepts one word-granular read or write request through a valid/ready handshake and models a fixed access latency with a counter.
- Holds a local word array and returns the read data or a write acknowledge through a second valid/ready response channel.
- Sits between the LSU request port and the future bus/SRAM model; it lets multi-cycle memory be exercised in the NPC.

---
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-array memory responder: one request at a time, fixed access latency,
// read data or write acknowledge returned on a valid/ready response channel.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // state  | meaning
  // IDLE   | ready for a request
  // WAIT   | latency countdown, request fields latched
  // RESP   | response presented until resp_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic          lat_wen;
  logic          lat_err;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_wmask;

  logic [31:0]   mem [DEPTH_WORDS];

  // Word-granular offset with a spare MSB so addresses below the base
  // show up as a borrow instead of wrapping into range.
  logic [30:0]   word_diff;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic [1:0]    unused_addr_lsb;

  assign unused_addr_lsb = req_addr[1:0];
  assign word_diff       = {1'b0, req_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign req_err         = word_diff[30] | (|word_diff[29:AW]);
  assign req_idx         = word_diff[AW-1:0];

  // Fields used on the edge entering RESP: live inputs when LATENCY=1 jumps
  // straight from IDLE, latched copies otherwise.
  logic          cur_wen;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wmask;
  logic          enter_resp;
  logic          mem_we;

  always_comb begin
    cur_wen   = lat_wen;
    cur_err   = lat_err;
    cur_idx   = lat_idx;
    cur_wdata = lat_wdata;
    cur_wmask = lat_wmask;
    if (state == S_IDLE) begin
      cur_wen   = req_wen;
      cur_err   = req_err;
      cur_idx   = req_idx;
      cur_wdata = req_wdata;
      cur_wmask = req_wmask;
    end
  end

  assign enter_resp = ((state == S_IDLE) && req_valid && (LATENCY == 1)) ||
                      ((state == S_WAIT) && (cnt == '0));
  assign mem_we     = enter_resp && cur_wen && !cur_err;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wmask[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_wen    <= 1'b0;
      lat_err    <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_wen   <= req_wen;
            lat_err   <= req_err;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              cnt   <= CW'(CNT_INIT);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - CW'(1);
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        resp_err   <= cur_err;
        resp_rdata <= (cur_wen || cur_err) ? 32'h0 : mem[cur_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed literal cases plus randomized traffic
// against a transaction-level model, and a LATENCY=1 back-to-back run.
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_wen;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_wmask;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, response visible once
  // LAT edges have passed since the accept edge, memory as a sparse word map.
  bit          m_busy;
  int          m_since;
  bit          m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_rdata;
  bit          m_err;
  bit          m_known;
  logic [31:0] mm [int];

  task automatic resolve();
    longint      off;
    int          idx;
    logic [31:0] w;
    off = $signed({32'h0, m_addr[31:2], 2'b00}) - $signed({32'h0, BASE});
    m_known = 1; m_rdata = 32'h0; m_err = 0;
    if (off < 0 || off >= 4 * DEPTH) begin
      m_err = 1;
    end else begin
      idx = int'(off / 4);
      if (m_wen) begin
        if (mm.exists(idx)) begin
          w = mm[idx];
          for (int i = 0; i < 4; i++) if (m_wmask[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
          mm[idx] = w;
        end else if (m_wmask == 4'hF) begin
          mm[idx] = m_wdata;
        end
      end else if (mm.exists(idx)) begin
        m_rdata = mm[idx];
      end else begin
        m_known = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    bit ev;
    if (!rst) begin
      m_busy = 0; m_since = 0;
      check("rst_req_ready", 32'(req_ready), 32'h1);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", 32'(resp_err), 32'h0);
    end else begin
      ev = m_busy && (m_since >= LAT);
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("resp_valid", 32'(resp_valid), 32'(ev));
      if (!ev || m_known) check("resp_rdata", resp_rdata, ev ? m_rdata : 32'h0);
      check("resp_err", 32'(resp_err), ev ? 32'(m_err) : 32'h0);
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_since = 1;
          m_wen = req_wen; m_addr = req_addr; m_wdata = req_wdata; m_wmask = req_wmask;
          if (m_since == LAT) resolve();
        end
      end else if (ev) begin
        if (resp_ready) m_busy = 0;
      end else begin
        m_since++;
        if (m_since == LAT) resolve();
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic do_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] mk, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = mk;
    @(posedge clk); #1;
    req_valid = 0; req_wen = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wmask = 4'($urandom);
    lat = 1;
    while (!resp_valid && lat < 50) begin
      resp_ready = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    check("resp_timeout", 32'(resp_valid), 32'h1);
    rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      resp_ready = 0; req_valid = 1'($urandom); req_wen = 1'($urandom); req_addr = $urandom;
      @(posedge clk); #1;
    end
    resp_ready = 1; req_valid = 0;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  task automatic b_write(input logic [31:0] a, input logic [31:0] d);
    b_req_valid = 1; b_req_wen = 1; b_req_addr = a; b_req_wdata = d; b_req_wmask = 4'hF;
    @(posedge clk); #1;
    b_req_valid = 0;
    check("b_wr_valid", 32'(b_resp_valid), 32'h1);
    b_resp_ready = 1;
    @(posedge clk); #1;
    b_resp_ready = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] bvals [3];
    logic [31:0] a;

    rst = 0; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wmask = 0;
    resp_ready = 0;
    b_req_valid = 0; b_req_wen = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wmask = 0;
    b_resp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    do_txn(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_rdata", rd, 32'h0);
    check("wr_err", 32'(er), 32'h0);
    do_txn(0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check("rd_full", rd, 32'hDEAD_BEEF);

    do_txn(1, 32'h8000_0012, 32'h00AB_0000, 4'b0100, 0, rd, er, lat);
    do_txn(0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    check("rd_byte", rd, 32'hDEAB_BEEF);
    do_txn(0, 32'h8000_0013, 32'h0, 4'h0, 0, rd, er, lat);
    check("rd_unaligned", rd, 32'hDEAB_BEEF);

    do_txn(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er, lat);
    check("below_err", 32'(er), 32'h1);
    check("below_rdata", rd, 32'h0);
    do_txn(0, 32'h8000_1000, 32'h0, 4'h0, 0, rd, er, lat);
    check("above_err", 32'(er), 32'h1);
    do_txn(1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
    do_txn(1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    check("above_wr_err", 32'(er), 32'h1);
    do_txn(0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lat);
    check("word0_kept", rd, 32'hCAFE_F00D);

    do_txn(1, 32'h8000_0010, 32'h1111_1111, 4'h0, 0, rd, er, lat);
    check("nomask_err", 32'(er), 32'h0);
    do_txn(0, 32'h8000_0010, 32'h0, 4'h0, 5, rd, er, lat);
    check("bp_rdata", rd, 32'hDEAB_BEEF);

    do_txn(1, 32'h8000_0020, 32'h0BAD_C0DE, 4'hF, 0, rd, er, lat);
    req_valid = 1; req_wen = 1; req_addr = 32'h8000_0020;
    req_wdata = 32'h1234_5678; req_wmask = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    #2 rst = 0;
    #1;
    check("async_req_ready", 32'(req_ready), 32'h1);
    check("async_resp_valid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1;
    do_txn(0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
    check("rst_dropped_wr", rd, 32'h0BAD_C0DE);

    for (int k = 0; k < 8; k++)
      do_txn(1, 32'h8000_0100 + 32'(4 * k), $urandom, 4'hF, 0, rd, er, lat);
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'(4 * $urandom_range(1, 100));
        1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
        2:       a = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFC;
        default: a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      endcase
      do_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er, lat);
    end

    bvals[0] = 32'h1111_1111; bvals[1] = 32'h2222_2222; bvals[2] = 32'h3333_3333;
    for (int k = 0; k < 3; k++) b_write(32'h8000_0040 + 32'(4 * k), bvals[k]);
    b_req_wen = 0; b_resp_ready = 1; b_req_valid = 1; b_req_addr = 32'h8000_0040;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("b_resp_valid", 32'(b_resp_valid), 32'((k % 2) == 0));
      check("b_req_ready", 32'(b_req_ready), 32'((k % 2) == 1));
      if ((k % 2) == 0) check("b_rdata", b_resp_rdata, bvals[k/2]);
      else b_req_addr = 32'h8000_0040 + 32'(4 * (k / 2 + 1));
    end
    b_req_valid = 0; b_resp_ready = 0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
